// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: message encodings,
// FSM state encoding and the round-robin pointer wrap helper.
package mem_port_arbiter_pkg;

  localparam logic [2:0] NO_REQ   = 3'd0;
  localparam logic [2:0] R_REQ    = 3'd1;
  localparam logic [2:0] WB_REQ   = 3'd2;
  localparam logic [2:0] MEM_RESP = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Next round-robin start position after slot idx has been served.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first valid slot found
// scanning ptr, ptr+1, ... modulo N, as both one-hot and index.
module mem_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from farthest to nearest so the slot closest to ptr wins last.
  always_comb begin
    int c;
    logic [IDX_W-1:0] c_idx;
    onehot = '0;
    idx    = '0;
    any    = |valid;
    c      = 0;
    c_idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      c_idx = IDX_W'(c);
      if (valid[c_idx]) begin
        onehot        = '0;
        onehot[c_idx] = 1'b1;
        idx           = c_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between NUM_REQ
// requesters; one outstanding transaction, responses routed back to the owner.
//
// state      | meaning
// ST_IDLE    | no owner; pick next valid requester from rr_ptr
// ST_WAIT    | request on arb2mem_*, waiting for matching MEM_RESP
// ST_RELEASE | response held on owner's rsp_*, waiting for it to drop
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_BITS    = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MSG_BITS       = 3,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int LINE_W        = DATA_WIDTH << OFFSET_BITS
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ*MSG_BITS-1:0]       req_msg,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_address,
  input  logic [NUM_REQ*LINE_W-1:0]         req_data,
  output logic [NUM_REQ*MSG_BITS-1:0]       rsp_msg,
  output logic [NUM_REQ*ADDRESS_WIDTH-1:0]  rsp_address,
  output logic [NUM_REQ*LINE_W-1:0]         rsp_data,
  output logic [MSG_BITS-1:0]               arb2mem_msg,
  output logic [ADDRESS_WIDTH-1:0]          arb2mem_address,
  output logic [LINE_W-1:0]                 arb2mem_data,
  input  logic [MSG_BITS-1:0]               mem2arb_msg,
  input  logic [ADDRESS_WIDTH-1:0]          mem2arb_address,
  input  logic [LINE_W-1:0]                 mem2arb_data,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [MSG_BITS-1:0] M_NO    = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_RESP  = MSG_BITS'(MEM_RESP);

  arb_state_e                      state, state_nxt;
  logic [IDX_W-1:0]                rr_ptr, rr_ptr_nxt, owner, owner_nxt;
  logic [NUM_REQ-1:0]              valid, pick_onehot, grant_nxt;
  logic [IDX_W-1:0]                pick_idx;
  logic                            pick_any;
  logic [CNT_W-1:0]                wait_cnt, wait_cnt_nxt;
  logic                            timeout_nxt;
  logic [MSG_BITS-1:0]             arb2mem_msg_nxt, own_msg;
  logic [ADDRESS_WIDTH-1:0]        arb2mem_address_nxt;
  logic [LINE_W-1:0]               arb2mem_data_nxt;
  logic [NUM_REQ*MSG_BITS-1:0]     rsp_msg_nxt;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] rsp_address_nxt;
  logic [NUM_REQ*LINE_W-1:0]       rsp_data_nxt;
  logic                            accept;

  // Per-slot request-valid vector.
  always_comb begin
    valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid[i] = (req_msg[i*MSG_BITS +: MSG_BITS] != M_NO);
    end
  end

  mem_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid  (valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign own_msg = req_msg[int'(owner)*MSG_BITS +: MSG_BITS];
  assign accept  = (mem2arb_msg == M_RESP) && (mem2arb_address == arb2mem_address);
  assign busy    = (state != ST_IDLE);

  // Next-state and next registered-output computation.
  always_comb begin
    state_nxt           = state;
    rr_ptr_nxt          = rr_ptr;
    owner_nxt           = owner;
    grant_nxt           = grant;
    wait_cnt_nxt        = wait_cnt;
    timeout_nxt         = timeout_err;
    arb2mem_msg_nxt     = arb2mem_msg;
    arb2mem_address_nxt = arb2mem_address;
    arb2mem_data_nxt    = arb2mem_data;
    rsp_msg_nxt         = rsp_msg;
    rsp_address_nxt     = rsp_address;
    rsp_data_nxt        = rsp_data;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          arb2mem_msg_nxt     = req_msg[int'(pick_idx)*MSG_BITS +: MSG_BITS];
          arb2mem_address_nxt = req_address[int'(pick_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          arb2mem_data_nxt    = req_data[int'(pick_idx)*LINE_W +: LINE_W];
          grant_nxt           = pick_onehot;
          owner_nxt           = pick_idx;
          wait_cnt_nxt        = '0;
          state_nxt           = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt != CNT_MAX) wait_cnt_nxt = wait_cnt + 1'b1;
        if (wait_cnt_nxt == CNT_MAX) timeout_nxt = 1'b1;
        if (accept) begin
          arb2mem_msg_nxt = M_NO;
          if (own_msg == M_NO) begin
            // Owner withdrew mid-flight: finish silently and move on.
            grant_nxt  = '0;
            rr_ptr_nxt = IDX_W'(rr_wrap(int'(owner), NUM_REQ));
            state_nxt  = ST_IDLE;
          end else begin
            rsp_msg_nxt[int'(owner)*MSG_BITS +: MSG_BITS]               = M_RESP;
            rsp_address_nxt[int'(owner)*ADDRESS_WIDTH +: ADDRESS_WIDTH] = arb2mem_address;
            rsp_data_nxt[int'(owner)*LINE_W +: LINE_W]                  = mem2arb_data;
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (own_msg == M_NO) begin
          rsp_msg_nxt[int'(owner)*MSG_BITS +: MSG_BITS] = M_NO;
          grant_nxt  = '0;
          rr_ptr_nxt = IDX_W'(rr_wrap(int'(owner), NUM_REQ));
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      grant           <= '0;
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
      arb2mem_msg     <= M_NO;
      arb2mem_address <= '0;
      arb2mem_data    <= '0;
      rsp_msg         <= {NUM_REQ{M_NO}};
      rsp_address     <= '0;
      rsp_data        <= '0;
    end else begin
      state           <= state_nxt;
      rr_ptr          <= rr_ptr_nxt;
      owner           <= owner_nxt;
      grant           <= grant_nxt;
      wait_cnt        <= wait_cnt_nxt;
      timeout_err     <= timeout_nxt;
      arb2mem_msg     <= arb2mem_msg_nxt;
      arb2mem_address <= arb2mem_address_nxt;
      arb2mem_data    <= arb2mem_data_nxt;
      rsp_msg         <= rsp_msg_nxt;
      rsp_address     <= rsp_address_nxt;
      rsp_data        <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions,
// round-robin rotation, address mismatch / withdraw, timeout, reset mid-WAIT.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int OB = 2;
  localparam int AW = 32;
  localparam int MB = 3;
  localparam int NR = 2;
  localparam int LW = DW << OB;
  localparam int TO = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic [NR*MB-1:0]    req_msg;
  logic [NR*AW-1:0]    req_address;
  logic [NR*LW-1:0]    req_data;
  logic [NR*MB-1:0]    rsp_msg;
  logic [NR*AW-1:0]    rsp_address;
  logic [NR*LW-1:0]    rsp_data;
  logic [MB-1:0]       arb2mem_msg;
  logic [AW-1:0]       arb2mem_address;
  logic [LW-1:0]       arb2mem_data;
  logic [MB-1:0]       mem2arb_msg;
  logic [AW-1:0]       mem2arb_address;
  logic [LW-1:0]       mem2arb_data;
  logic [NR-1:0]       grant;
  logic                busy;
  logic                timeout_err;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .DATA_WIDTH     (DW),
    .OFFSET_BITS    (OB),
    .ADDRESS_WIDTH  (AW),
    .MSG_BITS       (MB),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_msg         (req_msg),
    .req_address     (req_address),
    .req_data        (req_data),
    .rsp_msg         (rsp_msg),
    .rsp_address     (rsp_address),
    .rsp_data        (rsp_data),
    .arb2mem_msg     (arb2mem_msg),
    .arb2mem_address (arb2mem_address),
    .arb2mem_data    (arb2mem_data),
    .mem2arb_msg     (mem2arb_msg),
    .mem2arb_address (mem2arb_address),
    .mem2arb_data    (mem2arb_data),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          slot;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          slot;
    logic [MB-1:0] msg;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] mdata;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int s, input logic [MB-1:0] m, input logic [AW-1:0] a,
                         input logic [LW-1:0] d);
    req_msg[s*MB +: MB]     = m;
    req_address[s*AW +: AW] = a;
    req_data[s*LW +: LW]    = d;
  endtask

  task automatic drop(input int s);
    req_msg[s*MB +: MB] = NO_REQ;
  endtask

  task automatic mem_send(input logic [MB-1:0] m, input logic [AW-1:0] a, input logic [LW-1:0] d);
    mem2arb_msg     = m;
    mem2arb_address = a;
    mem2arb_data    = d;
  endtask

  task automatic mem_idle();
    mem_send(NO_REQ, '0, '0);
  endtask

  task automatic check_issue(input string tag, input int s, input logic [MB-1:0] m,
                             input logic [AW-1:0] a, input logic [LW-1:0] d);
    logic [NR-1:0] g;
    g    = '0;
    g[s] = 1'b1;
    chk({tag, " grant"}, LW'(grant), LW'(g));
    chk({tag, " busy"}, LW'(busy), LW'(1'b1));
    chk({tag, " arb2mem_msg"}, LW'(arb2mem_msg), LW'(m));
    chk({tag, " arb2mem_address"}, LW'(arb2mem_address), LW'(a));
    chk({tag, " arb2mem_data"}, arb2mem_data, d);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      for (int j = 0; j < NR; j++) begin
        if (j == e.slot) begin
          chk($sformatf("%s rsp_msg[%0d]", tag, j), LW'(rsp_msg[j*MB +: MB]), LW'(MEM_RESP));
          chk($sformatf("%s rsp_address[%0d]", tag, j), LW'(rsp_address[j*AW +: AW]), LW'(e.addr));
          chk($sformatf("%s rsp_data[%0d]", tag, j), rsp_data[j*LW +: LW], e.data);
        end else begin
          chk($sformatf("%s rsp_msg[%0d]", tag, j), LW'(rsp_msg[j*MB +: MB]), LW'(NO_REQ));
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " grant"}, LW'(grant), '0);
    chk({tag, " busy"}, LW'(busy), '0);
    chk({tag, " rsp_msg"}, LW'(rsp_msg), LW'({NR{NO_REQ}}));
  endtask

  // Complete the current WAIT transaction of slot s and release it.
  task automatic serve(input string tag, input int s, input logic [AW-1:0] a,
                       input logic [LW-1:0] md);
    sb.push_back('{s, a, md});
    mem_send(MEM_RESP, a, md);
    tick();
    mem_idle();
    check_rsp(tag);
    drop(s);
    tick();
    check_idle({tag, " released"});
  endtask

  initial begin
    logic [AW-1:0] cur_addr [NR];
    logic [LW-1:0] md;
    int rr_m;

    vecs[0] = '{0, R_REQ,  32'h0000_0040, '0,
                128'hCAFEF00D_12345678_9ABCDEF0_DEADBEEF};
    vecs[1] = '{1, WB_REQ, 32'h0000_0080, 128'h11223344_55667788_99AABBCC_DDEEFF00,
                128'h11223344_55667788_99AABBCC_DDEEFF00};
    vecs[2] = '{0, WB_REQ, 32'h0000_1000, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0,
                128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0};
    vecs[3] = '{1, R_REQ,  32'hFFFF_FFC0, '0,
                128'h01234567_89ABCDEF_FEDCBA98_76543210};
    vecs[4] = '{0, R_REQ,  32'h0000_0000, '0, '1};
    vecs[5] = '{1, R_REQ,  32'h0000_0240, '0,
                128'h0BADC0DE_00000001_80000000_13579BDF};

    reset   = 1'b1;
    req_msg = {NR{NO_REQ}};
    req_address = '0;
    req_data    = '0;
    mem_idle();
    #2 reset = 1'b0;
    #2;
    check_idle("reset");
    chk("reset timeout_err", LW'(timeout_err), '0);
    chk("reset arb2mem_msg", LW'(arb2mem_msg), LW'(NO_REQ));
    chk("reset arb2mem_address", LW'(arb2mem_address), '0);
    chk("reset arb2mem_data", arb2mem_data, '0);
    chk("reset rsp_address", LW'(rsp_address), '0);
    chk("reset rsp_data", rsp_data[LW-1:0], '0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Contention and strict rotation with both slots continuously requesting.
    rr_m = 0;
    cur_addr[0] = 32'h100;
    cur_addr[1] = 32'h200;
    set_req(0, R_REQ, cur_addr[0], '0);
    set_req(1, R_REQ, cur_addr[1], '0);
    for (int i = 0; i < 8; i++) begin
      int s;
      s = rr_m;
      tick();
      check_issue($sformatf("rot%0d", i), s, R_REQ, cur_addr[s], '0);
      md = {4{32'(i * 32'h01010101 + 32'h1000)}};
      sb.push_back('{s, cur_addr[s], md});
      mem_send(MEM_RESP, cur_addr[s], md);
      tick();
      mem_idle();
      check_rsp($sformatf("rot%0d", i));
      drop(s);
      tick();
      check_idle($sformatf("rot%0d release", i));
      cur_addr[s] = cur_addr[s] + 32'h10;
      set_req(s, R_REQ, cur_addr[s], '0);
      rr_m = (s + 1) % NR;
    end
    drop(0);
    drop(1);
    tick();

    // Single-slot transactions from the vector table.
    for (int v = 0; v < 6; v++) begin
      int s;
      s = vecs[v].slot;
      set_req(s, vecs[v].msg, vecs[v].addr, vecs[v].wdata);
      tick();
      check_issue($sformatf("vec%0d", v), s, vecs[v].msg, vecs[v].addr, vecs[v].wdata);
      sb.push_back('{s, vecs[v].addr, vecs[v].mdata});
      mem_send(MEM_RESP, vecs[v].addr, vecs[v].mdata);
      tick();
      mem_idle();
      check_rsp($sformatf("vec%0d", v));
      chk($sformatf("vec%0d arb2mem_msg cleared", v), LW'(arb2mem_msg), LW'(NO_REQ));
      mem_send(MEM_RESP, vecs[v].addr, ~vecs[v].mdata);
      tick();
      mem_idle();
      chk($sformatf("vec%0d hold rsp_msg", v), LW'(rsp_msg[s*MB +: MB]), LW'(MEM_RESP));
      chk($sformatf("vec%0d hold rsp_data", v), rsp_data[s*LW +: LW], vecs[v].mdata);
      drop(s);
      tick();
      check_idle($sformatf("vec%0d release", v));
    end

    // Address mismatch, wrong message, then owner withdraws before the real response.
    set_req(0, R_REQ, 32'h40, '0);
    tick();
    check_issue("wd", 0, R_REQ, 32'h40, '0);
    mem_send(MEM_RESP, 32'h44, '1);
    tick();
    chk("wd mismatch busy", LW'(busy), LW'(1'b1));
    chk("wd mismatch arb2mem_msg", LW'(arb2mem_msg), LW'(R_REQ));
    chk("wd mismatch rsp_msg", LW'(rsp_msg), LW'({NR{NO_REQ}}));
    mem_send(R_REQ, 32'h40, '1);
    tick();
    chk("wd wrongmsg busy", LW'(busy), LW'(1'b1));
    chk("wd wrongmsg rsp_msg", LW'(rsp_msg), LW'({NR{NO_REQ}}));
    drop(0);
    mem_send(MEM_RESP, 32'h40, '1);
    tick();
    mem_idle();
    check_idle("wd withdrawn");
    chk("wd arb2mem_msg", LW'(arb2mem_msg), LW'(NO_REQ));
    set_req(0, R_REQ, 32'h600, '0);
    set_req(1, R_REQ, 32'h700, '0);
    tick();
    check_issue("wd next", 1, R_REQ, 32'h700, '0);
    serve("wd s1", 1, 32'h700, 128'h7);
    tick();
    check_issue("wd then", 0, R_REQ, 32'h600, '0);
    serve("wd s0", 0, 32'h600, 128'h6);

    // Silent memory: timeout flag after TO WAIT cycles, sticky afterwards.
    chk("tmo before", LW'(timeout_err), '0);
    set_req(1, R_REQ, 32'h300, '0);
    tick();
    check_issue("tmo", 1, R_REQ, 32'h300, '0);
    repeat (TO - 1) tick();
    chk("tmo at TO-1", LW'(timeout_err), '0);
    tick();
    chk("tmo at TO", LW'(timeout_err), LW'(1'b1));
    repeat (5) tick();
    chk("tmo still waiting", LW'(busy), LW'(1'b1));
    chk("tmo arb2mem_msg held", LW'(arb2mem_msg), LW'(R_REQ));
    serve("tmo", 1, 32'h300, 128'h3030);
    chk("tmo sticky", LW'(timeout_err), LW'(1'b1));

    // Reset asserted in WAIT abandons the transaction.
    set_req(0, R_REQ, 32'h500, '0);
    tick();
    check_issue("rst", 0, R_REQ, 32'h500, '0);
    reset = 1'b0;
    #1;
    check_idle("rst async");
    chk("rst arb2mem_msg", LW'(arb2mem_msg), LW'(NO_REQ));
    chk("rst arb2mem_address", LW'(arb2mem_address), '0);
    chk("rst arb2mem_data", arb2mem_data, '0);
    chk("rst timeout_err", LW'(timeout_err), '0);
    mem_send(MEM_RESP, 32'h500, '1);
    tick();
    mem_idle();
    check_idle("rst held");
    reset = 1'b1;
    tick();
    check_issue("rst reissue", 0, R_REQ, 32'h500, '0);
    serve("rst", 0, 32'h500, 128'h5050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
